// File: rtl/spart_pkg.sv
// Shared constants, types and the baud divisor helper for the SPART driver.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    typedef enum logic [1:0] {
        Baud4800  = 2'b00,
        Baud9600  = 2'b01,
        Baud19200 = 2'b10,
        Baud38400 = 2'b11
    } baud_t;

    typedef enum logic [2:0] {
        StInitLo,
        StInitHi,
        StIdle,
        StRdRx,
        StWrTx
    } drv_state_t;

    // round(clk_hz / (16 * baud)) - 1
    function automatic logic [15:0] divisor_for(baud_t b, int unsigned clk_hz);
        int unsigned baud;
        case (b)
            Baud4800:  baud = 4800;
            Baud9600:  baud = 9600;
            Baud19200: baud = 19200;
            default:   baud = 38400;
        endcase
        return 16'((clk_hz + 8 * baud) / (16 * baud) - 1);
    endfunction

endpackage

// File: rtl/spart_driver_if.sv
// SPART register-interface control and status signals.
interface spart_driver_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (
        output iocs,
        output iorw,
        output ioaddr,
        input  rda,
        input  tbr
    );

    modport slave (
        input  iocs,
        input  iorw,
        input  ioaddr,
        output rda,
        output tbr
    );

endinterface

// File: rtl/spart_echo_fifo.sv
// Small circular byte FIFO holding received bytes awaiting echo.
module spart_echo_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [7:0]                  din_i,
    output logic [7:0]                  dout_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer/occupancy update; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (push_i && !full_o) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
            count_q         <= count_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/spart_driver.sv
// Bus master for the SPART: programs the baud divisor and echoes received bytes.
module spart_driver
    import spart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_HZ     = 50_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  br_cfg,
    spart_driver_if.master              bus,
    inout  wire  [7:0]                  databus,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam logic [15:0] DivTable [4] = '{
        divisor_for(Baud4800,  CLK_HZ),
        divisor_for(Baud9600,  CLK_HZ),
        divisor_for(Baud19200, CLK_HZ),
        divisor_for(Baud38400, CLK_HZ)
    };

    drv_state_t state_q, state_d;
    logic [1:0] br_q;       // registered switch input
    logic [1:0] cfg_q;      // baud setting last written to the SPART
    logic       rx_pending_q;
    logic       holdoff_q;
    logic       overrun_q;

    logic       iocs_c;
    logic       iorw_c;
    logic [1:0] ioaddr_c;
    logic [7:0] dout_c;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [7:0] head;
    logic       br_change;
    logic       iocs_g;

    assign br_change = (br_q != cfg_q);

    spart_echo_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (rst),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (databus),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty),
        .count_o(fifo_count)
    );

    // State, sticky flags and baud tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StInitLo;
            br_q         <= br_cfg;
            cfg_q        <= br_cfg;
            rx_pending_q <= 1'b0;
            holdoff_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            br_q         <= br_cfg;
            if (state_q == StInitLo) begin
                cfg_q <= br_q;
            end
            // A new rda in the completing RD_RX cycle re-arms the flag.
            rx_pending_q <= bus.rda | (rx_pending_q & (state_q != StRdRx));
            holdoff_q    <= (state_q == StWrTx);
            if (state_q == StRdRx && full) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Next-state and bus-cycle decode.
    always_comb begin
        state_d  = state_q;
        iocs_c   = 1'b0;
        iorw_c   = 1'b1;
        ioaddr_c = ADDR_BUF;
        dout_c   = 8'h00;
        push     = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            StInitLo: begin
                iocs_c   = 1'b1;
                iorw_c   = 1'b0;
                ioaddr_c = ADDR_DB_LO;
                dout_c   = DivTable[br_q][7:0];
                state_d  = StInitHi;
            end
            StInitHi: begin
                iocs_c   = 1'b1;
                iorw_c   = 1'b0;
                ioaddr_c = ADDR_DB_HI;
                dout_c   = DivTable[cfg_q][15:8];
                state_d  = br_change ? StInitLo : StIdle;
            end
            StIdle: begin
                // A same-cycle rda beats a pending transmit.
                if (br_change) begin
                    state_d = StInitLo;
                end else if (rx_pending_q || bus.rda) begin
                    state_d = StRdRx;
                end else if (!empty && bus.tbr && !holdoff_q) begin
                    state_d = StWrTx;
                end
            end
            StRdRx: begin
                iocs_c   = 1'b1;
                ioaddr_c = ADDR_BUF;
                push     = !full;
                state_d  = br_change ? StInitLo : StIdle;
            end
            StWrTx: begin
                iocs_c   = 1'b1;
                iorw_c   = 1'b0;
                ioaddr_c = ADDR_BUF;
                dout_c   = head;
                pop      = 1'b1;
                state_d  = br_change ? StInitLo : StIdle;
            end
            default: state_d = StInitLo;
        endcase
    end

    // Reset abandons any bus cycle in the same clock.
    assign iocs_g     = iocs_c & rst;
    assign bus.iocs   = iocs_g;
    assign bus.iorw   = iorw_c | ~rst;
    assign bus.ioaddr = rst ? ioaddr_c : ADDR_BUF;
    assign databus    = (iocs_g && !iorw_c) ? dout_c : 8'hzz;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench with a bus-cycle scoreboard for spart_driver.
module tb_spart_driver;
    import spart_pkg::*;

    localparam int unsigned Depth = 4;

    typedef struct packed {
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
    } txn_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             br_cfg;
    logic [7:0]             rx_byte;
    logic                   overrun;
    logic [$clog2(Depth):0] fifo_count;
    wire  [7:0]             databus;

    int   tests = 0;
    int   fails = 0;
    txn_t sb[$];
    txn_t got_t;
    txn_t exp_t;
    logic prev_tx_wr = 1'b0;
    int   fc_saved;

    spart_driver_if bus_if ();

    spart_driver #(
        .FIFO_DEPTH(Depth),
        .CLK_HZ    (50_000_000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .br_cfg    (br_cfg),
        .bus       (bus_if.master),
        .databus   (databus),
        .overrun   (overrun),
        .fifo_count(fifo_count)
    );

    // SPART receive buffer model: combinational read mux.
    assign databus = (bus_if.iocs && bus_if.iorw && bus_if.ioaddr == ADDR_BUF) ? rx_byte : 8'hzz;

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(string tag, int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic exp_push(logic rw, logic [1:0] addr, logic [7:0] data);
        txn_t t;
        t.rw   = rw;
        t.addr = addr;
        t.data = data;
        sb.push_back(t);
    endtask

    task automatic pulse_rda();
        bus_if.rda = 1'b1;
        tick(1);
        bus_if.rda = 1'b0;
    endtask

    // Bus monitor: every observed cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && bus_if.iocs) begin
            got_t.rw   = bus_if.iorw;
            got_t.addr = bus_if.ioaddr;
            got_t.data = bus_if.iorw ? 8'h00 : databus;
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_bus_cycle observed=%0h expected=none", got_t);
            end
            if (sb.size() != 0) begin
                exp_t = sb.pop_front();
                check("bus_cycle", 32'(got_t), 32'(exp_t));
            end
            if (!bus_if.iorw && bus_if.ioaddr == ADDR_BUF) begin
                check("tx_gap", 32'(prev_tx_wr), 0);
            end
        end
        prev_tx_wr <= rst && bus_if.iocs && !bus_if.iorw && (bus_if.ioaddr == ADDR_BUF);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b0;
        br_cfg     = 2'b01;
        rx_byte    = 8'h00;
        bus_if.rda = 1'b0;
        bus_if.tbr = 1'b0;
        tick(3);
        check("rst_iocs", bus_if.iocs, 1'b0);
        check("rst_iorw", bus_if.iorw, 1'b1);
        check("rst_ioaddr", bus_if.ioaddr, 2'b00);
        check("rst_overrun", overrun, 1'b0);
        check("rst_fifo_count", fifo_count, 0);

        // Divisor programming after reset, 9600 baud.
        exp_push(1'b0, ADDR_DB_LO, 8'h45);
        exp_push(1'b0, ADDR_DB_HI, 8'h01);
        rst = 1'b1;
        #1;
        check("init_lo_cycle", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, 4'b1010);
        tick(1);
        check("init_hi_cycle", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, 4'b1011);
        tick(1);
        check("init_done_idle", bus_if.iocs, 1'b0);
        wait_drain("init_drain", 10);

        // Baud change while idle, 38400.
        fc_saved = int'(fifo_count);
        exp_push(1'b0, ADDR_DB_LO, 8'h50);
        exp_push(1'b0, ADDR_DB_HI, 8'h00);
        br_cfg = 2'b11;
        tick(3);
        check("rebaud_hi_by_3", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, 4'b1011);
        tick(1);
        check("rebaud_fifo_kept", fifo_count, fc_saved);
        wait_drain("rebaud_drain", 10);

        // Single echo.
        bus_if.tbr = 1'b1;
        rx_byte    = 8'h41;
        exp_push(1'b1, ADDR_BUF, 8'h00);
        exp_push(1'b0, ADDR_BUF, 8'h41);
        pulse_rda();
        check("echo_read_cycle", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, 4'b1100);
        check("echo_count0", fifo_count, 0);
        tick(1);
        check("echo_count1", fifo_count, 1);
        tick(2);
        check("echo_count_back0", fifo_count, 0);
        wait_drain("echo_drain", 10);

        // Fill past capacity with transmit blocked.
        bus_if.tbr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_byte = 8'h31 + 8'(i);
            exp_push(1'b1, ADDR_BUF, 8'h00);
            pulse_rda();
            tick(3);
        end
        check("full_count", fifo_count, Depth);
        check("full_overrun", overrun, 1'b1);
        wait_drain("full_reads_drain", 5);
        for (int i = 0; i < 4; i++) begin
            exp_push(1'b0, ADDR_BUF, 8'h31 + 8'(i));
        end
        bus_if.tbr = 1'b1;
        wait_drain("full_tx_drain", 40);
        tick(2);
        check("full_tx_count", fifo_count, 0);
        check("overrun_sticky", overrun, 1'b1);

        // rda coincident with an eligible transmit: receive goes first.
        bus_if.tbr = 1'b0;
        rx_byte    = 8'h61;
        exp_push(1'b1, ADDR_BUF, 8'h00);
        pulse_rda();
        tick(3);
        check("prio_pre_count", fifo_count, 1);
        rx_byte    = 8'h62;
        exp_push(1'b1, ADDR_BUF, 8'h00);
        exp_push(1'b0, ADDR_BUF, 8'h61);
        exp_push(1'b0, ADDR_BUF, 8'h62);
        bus_if.tbr = 1'b1;
        pulse_rda();
        wait_drain("prio_drain", 30);
        tick(2);
        check("prio_count", fifo_count, 0);

        // Reset in the middle of a read cycle.
        bus_if.tbr = 1'b0;
        rx_byte    = 8'h70;
        exp_push(1'b1, ADDR_BUF, 8'h00);
        pulse_rda();
        tick(3);
        check("mid_pre_count", fifo_count, 1);
        rx_byte = 8'h77;
        pulse_rda();
        check("mid_in_read", {bus_if.iocs, bus_if.iorw}, 2'b11);
        rst = 1'b0;
        tick(1);
        check("mid_rst_iocs", bus_if.iocs, 1'b0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_overrun", overrun, 1'b0);
        tick(2);
        exp_push(1'b0, ADDR_DB_LO, 8'h50);
        exp_push(1'b0, ADDR_DB_HI, 8'h00);
        rst = 1'b1;
        #1;
        check("mid_reinit_first", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, 4'b1010);
        wait_drain("mid_reinit_drain", 10);
        tick(10);
        check("final_sb_empty", sb.size(), 0);
        check("final_count", fifo_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
